// File: rtl/apb_req.sv
// APB5 requester: accepts one command on a valid/ready channel, runs SETUP/ACCESS
// on the APB bus, and returns read data and error status on a response channel.
module apb_req #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ERR_CNT_W      = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  // command channel
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_strb,
  input  logic [2:0]           cmd_prot,
  // response channel
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic [ERR_CNT_W-1:0] err_count,
  // APB bus
  output logic                 psel,
  output logic                 penable,
  output logic [31:0]          paddr,
  output logic                 pwrite,
  output logic [31:0]          pwdata,
  output logic [3:0]           pstrb,
  output logic [2:0]           pprot,
  input  logic [31:0]          prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [31:0]           r_paddr;
  logic                  r_pwrite;
  logic [31:0]           r_pwdata;
  logic [3:0]            r_pstrb;
  logic [2:0]            r_pprot;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_timeout;
  logic [ERR_CNT_W-1:0]  r_err_count;

  logic w_accept;
  logic w_done;
  logic w_abort;
  logic w_finish;
  logic w_fin_err;
  logic w_timeout_hit;

  // The response slot must be empty or draining this cycle before a new command is taken.
  assign cmd_ready     = (r_state == S_IDLE) && !preset && (!r_rsp_valid || rsp_ready);
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == WAIT_MAX);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (pready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_timeout_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_finish  = w_done || w_abort;
  assign w_fin_err = w_abort || (w_done && pslverr);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
      r_pprot  <= '0;
    end else if (w_accept) begin
      r_paddr  <= cmd_addr;
      r_pwrite <= cmd_write;
      r_pwdata <= cmd_wdata;
      r_pstrb  <= cmd_write ? cmd_strb : 4'b0000;
      r_pprot  <= cmd_prot;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_wait_cnt <= '0;
    end else if (w_accept) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !pready && !w_timeout_hit) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else if (w_finish) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= (w_abort || r_pwrite) ? 32'h0 : prdata;
      r_rsp_err     <= w_fin_err;
      r_rsp_timeout <= w_abort;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_err_count <= '0;
    end else if (w_finish && w_fin_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign psel        = (r_state != S_IDLE);
  assign penable     = (r_state == S_ACCESS);
  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign pprot       = r_pprot;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_apb_req.sv
// Directed bench for apb_req: a vector table of single transfers plus hand-written
// sequences for response backpressure, back-to-back spacing and reset mid-ACCESS.
module tb_apb_req;

  logic        pclk;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] err_count;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_req #(.TIMEOUT_CYCLES(16), .ERR_CNT_W(16)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .err_count   (err_count),
    .psel        (psel),
    .penable     (penable),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pprot       (pprot),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;      // ACCESS cycles with pready low before pready rises
    logic        slverr;     // pslverr value on the completing cycle
    logic        noise;      // pslverr value while it must be ignored
    logic [31:0] prdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    logic [3:0]  exp_strb;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];
  int   n_total = 0;
  int   n_pass  = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   e;
    logic setup_ok;
    logic stable_ok;
    string tag;
    tag = $sformatf("v%0d", idx);
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    cmd_prot  = v.prot;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    #1;
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    setup_ok = psel && !penable && (paddr == v.addr) && (pwrite == v.wr) &&
               (pprot == v.prot) && (!v.wr || (pwdata == v.wdata));
    check({tag, "_setup"}, 32'(setup_ok), 32'd1);
    check({tag, "_pstrb"}, 32'(pstrb), 32'(v.exp_strb));
    e = 0;
    stable_ok = 1'b1;
    while (!rsp_valid && e < 40) begin
      if (e == 0) begin
        pready  = 1'b1;  // must be ignored in SETUP
        pslverr = v.noise;
        prdata  = 32'hBAD0_FFFF;
      end else begin
        if (!(psel && penable && (paddr == v.addr) && (pwrite == v.wr) &&
              (pstrb == v.exp_strb) && (pprot == v.prot) && (!v.wr || (pwdata == v.wdata))))
          stable_ok = 1'b0;
        pready  = ((e - 1) == v.waits);
        pslverr = pready ? v.slverr : v.noise;
        prdata  = pready ? v.prdata : (32'hBAD0_0000 | 32'(e));
      end
      step();
      e++;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    if (v.exp_err) exp_cnt++;
    check({tag, "_stable"},    32'(stable_ok),   32'd1);
    check({tag, "_latency"},   32'(e),           32'(v.exp_lat));
    check({tag, "_rdata"},     rsp_rdata,        v.exp_rdata);
    check({tag, "_err"},       32'(rsp_err),     32'(v.exp_err));
    check({tag, "_timeout"},   32'(rsp_timeout), 32'(v.exp_to));
    check({tag, "_bus_idle"},  32'({psel, penable}), 32'd0);
    check({tag, "_err_count"}, 32'(err_count),   32'(exp_cnt));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_rsp_drained"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic bad;
    int   n;

    //            wr    addr          wdata         strb  prot    waits slverr noise prdata        exp_rdata     err   to    estrb  lat
    vecs[0] = '{1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 4'hF, 3'b010, 0,    1'b0, 1'b0, 32'h1234_5678, 32'h0,        1'b0, 1'b0, 4'hF,  2};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 3'b000, 3,    1'b0, 1'b0, 32'h0000_0004, 32'h0000_0004, 1'b0, 1'b0, 4'h0,  5};
    vecs[2] = '{1'b0, 32'h0000_0082, 32'h0000_0000, 4'h0, 3'b000, 0,    1'b1, 1'b0, 32'hCAFE_0001, 32'hCAFE_0001, 1'b1, 1'b0, 4'h0,  2};
    vecs[3] = '{1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'h5, 3'b001, 2,    1'b0, 1'b1, 32'h7777_7777, 32'h0,        1'b0, 1'b0, 4'h5,  4};
    vecs[4] = '{1'b0, 32'h0000_0200, 32'h0000_0000, 4'h0, 3'b110, 1000, 1'b0, 1'b0, 32'h5555_5555, 32'h0,        1'b1, 1'b1, 4'h0, 18};
    vecs[5] = '{1'b1, 32'h0000_0300, 32'h0102_0304, 4'h3, 3'b000, 16,   1'b1, 1'b0, 32'h9999_9999, 32'h0,        1'b1, 1'b0, 4'h3, 18};

    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    #2;
    cmd_valid = 1'b1;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_bus",       32'({psel, penable, pwrite, pstrb, pprot}), 32'd0);
    check("rst_paddr",     paddr, 32'd0);
    check("rst_rsp",       32'({rsp_valid, rsp_err, rsp_timeout}), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    cmd_valid = 1'b0;
    repeat (2) step();
    preset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
      step();
    end

    // Response backpressure with cmd_valid held high, then back-to-back spacing.
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0040;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    pready    = 1'b1;
    prdata    = 32'h0000_0011;
    step();  // SETUP
    step();  // ACCESS
    step();  // completion
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_ready || psel || !rsp_valid) bad = 1'b1;
      step();
    end
    check("bp_blocked", 32'(bad), 32'd0);
    check("bp_rdata",   rsp_rdata, 32'h0000_0011);
    rsp_ready = 1'b1;
    #1;
    check("bp_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge pclk);
    #1;
    check("bp_next_setup", 32'({psel, penable, rsp_valid}), 32'b100);
    n = 0;
    do begin
      step();
      n++;
    end while (!(psel && !penable) && n < 10);
    cmd_valid = 1'b0;
    check("b2b_spacing", 32'(n), 32'd3);
    repeat (3) step();
    rsp_ready = 1'b0;
    check("b2b_drained", 32'({rsp_valid, psel}), 32'd0);

    // Reset asserted during an ACCESS wait state.
    pready    = 1'b0;
    cmd_addr  = 32'h0000_0050;
    cmd_valid = 1'b1;
    step();  // SETUP
    cmd_valid = 1'b0;
    step();  // ACCESS, wait 1
    step();  // ACCESS, wait 2
    check("mid_access", 32'({psel, penable}), 32'b11);
    preset = 1'b1;
    #1;
    check("rst_async_bus", 32'({psel, penable, rsp_valid}), 32'd0);
    check("rst_async_cnt", 32'(err_count), 32'd0);
    check("rst_async_rdy", 32'(cmd_ready), 32'd0);
    @(posedge pclk);
    #2;
    preset = 1'b0;
    #1;
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    pready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid || psel) bad = 1'b1;
    end
    check("rel_no_response", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_req.md
# apb_req

APB5 requester (bridge) that sits directly upstream of the APB5 completer and drives its APB bus. It accepts one command at a time on a valid/ready command channel and runs the APB SETUP and ACCESS phases, including wait states. It returns read data and error status on a valid/ready response channel. A programmable watchdog aborts transfers stuck on `pready` low, and a saturating counter tracks error responses.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS cycles with `pready` low before abort; 0 disables the watchdog.
- `ERR_CNT_W`, default 16: width of the error counter.
- `pclk` in 1: clock; all logic is on the rising edge.
- `preset` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when both valid and ready are high at a rising edge.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: byte address.
- `cmd_wdata` in 32: write data.
- `cmd_strb` in 4: byte strobes, used on writes only.
- `cmd_prot` in 3: protection attributes; bit1 = non-secure.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when valid and ready are both high at a rising edge.
- `rsp_rdata` out 32: read data; 0 for writes and for timed-out transfers.
- `rsp_err` out 1: `pslverr` was sampled high, or the transfer timed out.
- `rsp_timeout` out 1: the transfer was aborted by the watchdog.
- `err_count` out ERR_CNT_W: saturating count of responses with `rsp_err`=1.
- APB outputs: `psel` 1, `penable` 1, `paddr` 32, `pwrite` 1, `pwdata` 32, `pstrb` 4, `pprot` 3.
- APB inputs: `prdata` 32, `pready` 1, `pslverr` 1.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - `psel`=0, `penable`=0.
  - `cmd_ready` = (state==IDLE) && !preset && (!rsp_valid || rsp_ready). This is combinational.
  - On accept, register `cmd_*` into `paddr`/`pwrite`/`pwdata`/`pstrb`/`pprot` and go to SETUP.
  - For a read, `pstrb` is forced to 4'b0000.
- SETUP: `psel`=1, `penable`=0 for exactly one cycle, then ACCESS.
- ACCESS: `psel`=1, `penable`=1. Address, control and data are held stable.
  - If `pready`=1, the transfer completes:
    - load `rsp_rdata` = pwrite ? 0 : `prdata`;
    - load `rsp_err` = `pslverr`, `rsp_timeout`=0;
    - set `rsp_valid`=1;
    - go to IDLE.
  - If `pready`=0, the wait counter increments. When the counter equals `TIMEOUT_CYCLES` (and `TIMEOUT_CYCLES`≠0), the transfer aborts:
    - `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0, `rsp_valid`=1;
    - go to IDLE.
  - The wait counter clears on entry to SETUP. It is wide enough for `TIMEOUT_CYCLES` (`$clog2(TIMEOUT_CYCLES+1)`, minimum 1 bit).
- Response register:
  - `rsp_valid` clears on a handshake, unless a new completion lands in the same cycle.
  - A new completion cannot be pending while `rsp_valid`=1, because accept requires the slot to be free or draining.
- `err_count`:
  - increments by 1 on every completion or abort with `rsp_err`=1;
  - saturates at all-ones and never wraps.
- `pslverr` is ignored unless `psel`, `penable` and `pready` are all 1.
- Reset values (asserted asynchronously, held while `preset`=1):
  - state IDLE;
  - `psel`, `penable`, `pwrite`=0;
  - `paddr`, `pwdata`=0; `pstrb`, `pprot`=0;
  - `rsp_valid`, `rsp_err`, `rsp_timeout`=0; `rsp_rdata`=0;
  - `err_count`=0; wait counter=0;
  - `cmd_ready`=0.
- Reset mid-transfer: the bus returns to idle immediately and asynchronously. The transfer is dropped, no response is produced, and `err_count` clears.

## Timing
- Command accepted at edge E0:
  - SETUP (`psel`=1, `penable`=0) is visible after E0;
  - ACCESS is visible after E1.
- With zero wait states, `pready` is sampled high at E2 and `rsp_valid`=1 after E2. Accept-to-response latency is 2 edges.
- Each wait state adds 1 cycle. N wait states give a latency of 2+N edges.
- Timeout: abort at the edge where the wait count reaches `TIMEOUT_CYCLES`. `rsp_valid` rises `TIMEOUT_CYCLES`+2 edges after accept.
- Minimum spacing between accepts is 3 edges: SETUP, ACCESS, one IDLE cycle. `psel` is low for at least one cycle between transfers.
- If `rsp_ready` is held high, back-to-back commands sustain one transfer per 3 cycles.

## Test plan
- **Write, no wait states:**
  - Stimulus: write, addr 0x0000_0080, wdata 0xDEAD_BEEF, strb 0xF, prot 3'b010; `pready`=1.
  - Required: `psel` high for 2 cycles, `penable` high in the second; `pstrb`=0xF; `rsp_valid` 2 edges after accept with `rsp_err`=0 and `rsp_rdata`=0.
- **Read, 3 wait states:**
  - Stimulus: read, addr 0x0000_0010; `pready` low for 3 ACCESS cycles; `prdata`=0x0000_0004.
  - Required: `pstrb`=0; APB signals stable throughout ACCESS; `rsp_valid` 5 edges after accept; `rsp_rdata`=0x0000_0004.
- **Error response:**
  - Stimulus: read, addr 0x0000_0082; the completer returns `pslverr`=1.
  - Required: `rsp_err`=1, `rsp_timeout`=0, `err_count` 0→1.
- **Watchdog abort:**
  - Stimulus: `TIMEOUT_CYCLES`=16; `pready` held at 0.
  - Required: abort after 16 ACCESS cycles with `psel`/`penable` dropping; `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- **Response backpressure:**
  - Stimulus: `rsp_ready`=0 for 5 cycles after a completion; `cmd_valid` held high.
  - Required: `cmd_ready`=0 and `psel`=0 until the handshake; the next SETUP starts the edge after `rsp_ready` rises.
- **Reset mid-ACCESS:**
  - Stimulus: assert `preset` during a wait state.
  - Required: `psel`, `penable` and `rsp_valid` go to 0 immediately; `err_count`=0; no response after release; `cmd_ready`=1 on the first cycle after release.
